// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program memory sequencer streaming instruction words over valid/ready
module instr_fetch_unit #(
  parameter int DATA_W  = 50,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter bit LOOP_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              loop,
  input  logic              abort,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic [ADDR_W-1:0] pc, start_r, end_r, rd_a;
  logic              rd_pend;
  logic [DATA_W-1:0] b_data [2];
  logic [ADDR_W-1:0] b_addr [2];
  logic [1:0]        count, count_nx;
  logic              pop, issue, drained, relaunch, wp, done_q, wr_err_q;
  // occupancy after this edge counts the in-flight read as landing, so issue keeps one word per cycle
  always_comb begin
    pop      = (count != 2'd0) & instr_ready;
    count_nx = count + 2'(rd_pend) - 2'(pop);
    issue    = state == FETCH && !abort && count_nx < 2'd2;
    drained  = state == DRAIN && count_nx == 2'd0;
    relaunch = LOOP_EN && loop;
    wp       = count[1] | (count[0] & ~pop);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state: abort dominates everything, including a start seen in IDLE
  always_comb
    state_nx = abort ? IDLE :
               state == IDLE  ? (start ? FETCH : IDLE) :
               state == FETCH ? ((issue && pc == end_r) ? DRAIN : FETCH) :
               drained ? (relaunch ? FETCH : IDLE) : state;
  // outputs: buffer head is masked to zero whenever nothing is valid
  always_comb begin
    busy        = state != IDLE;
    instr_valid = count != 2'd0;
    instr_data  = instr_valid ? b_data[0] : '0;
    instr_addr  = instr_valid ? b_addr[0] : '0;
    done        = done_q;
    wr_err      = wr_err_q;
  end
  // PC sequencing, read tracking, 2-entry shift buffer and status pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc       <= '0;
      start_r  <= '0;
      end_r    <= '0;
      rd_a     <= '0;
      rd_pend  <= 1'b0;
      count    <= '0;
      b_data   <= '{default: '0};
      b_addr   <= '{default: '0};
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      if (state == IDLE && start && !abort) begin
        pc      <= start_addr;
        start_r <= start_addr;
        end_r   <= end_addr;
      end else if (issue) pc <= pc + 1'b1;
      else if (state == DRAIN && state_nx == FETCH) pc <= start_r;
      rd_pend <= issue;
      if (issue) rd_a <= pc;
      count <= abort ? 2'd0 : count_nx;
      if (pop) begin
        b_data[0] <= b_data[1];
        b_addr[0] <= b_addr[1];
      end
      if (rd_pend) begin
        b_data[wp] <= rd_q;
        b_addr[wp] <= rd_a;
      end
      done_q   <= drained && !relaunch && !abort;
      wr_err_q <= wr_en && state != IDLE;
    end
  // program memory: synchronous read, writes accepted only while idle, contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) mem[wr_addr] <= wr_data;
    if (issue) rd_q <= mem[pc];
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vectors plus corner-case sequences for instr_fetch_unit
module tb_instr_fetch_unit;
  localparam int DW = 50;
  localparam int AW = 4;
  localparam logic [DW-1:0] PAT  = 50'h2AAAA_AAAA_AAAA;
  localparam logic [DW-1:0] PAT2 = 50'h1_5555_5555_5555;
  logic clk = 0, rst_n = 0, start = 0, loop = 0, abort = 0, wr_en = 0, instr_ready = 0;
  logic [AW-1:0] start_addr = 0, end_addr = 0, wr_addr = 0;
  logic [DW-1:0] wr_data = 0;
  logic wr_err, instr_valid, busy, done;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_addr;
  int checks = 0, errors = 0;
  typedef struct {
    logic [AW-1:0] sa;
    logic [AW-1:0] ea;
    int            n;
    logic [AW-1:0] last;
  } vec_t;
  vec_t v [4];

  instr_fetch_unit #(.DATA_W(DW), .DEPTH(16), .LOOP_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .end_addr(end_addr),
    .loop(loop), .abort(abort), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_addr(instr_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [AW-1:0] sa, input logic [AW-1:0] ea);
    @(negedge clk);
    start = 1; start_addr = sa; end_addr = ea;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string name);
    bit s = 0;
    for (int c = 0; c < 40 && !s; c++) begin
      @(negedge clk);
      s = done;
    end
    chk(name, 64'(s), 64'd1);
  endtask

  task automatic single(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bit s = 0;
    instr_ready = 1;
    launch(a, a);
    for (int c = 0; c < 10 && !s; c++) begin
      @(negedge clk);
      s = instr_valid;
    end
    chk({name, "_valid"}, 64'(s), 64'd1);
    chk({name, "_data"}, 64'(instr_data), 64'(exp));
    wait_done({name, "_done"});
  endtask

  initial begin
    int k, n;
    bit seen, held, early;
    logic [AW-1:0] hold_a, exp_a;
    logic [DW-1:0] hold_d;
    v[0] = '{4'd0, 4'd3, 4, 4'd3};
    v[1] = '{4'd14, 4'd1, 4, 4'd1};
    v[2] = '{4'd7, 4'd7, 1, 4'd7};
    v[3] = '{4'd5, 4'd9, 5, 4'd9};
    #1;
    chk("rst_valid", 64'(instr_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_wr_err", 64'(wr_err), 0);
    chk("rst_data", 64'(instr_data), 0);
    chk("rst_addr", 64'(instr_addr), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    // program image: word i holds i
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wr_en = 1; wr_addr = AW'(i); wr_data = DW'(i);
    end
    @(negedge clk);
    wr_en = 0;
    chk("preload_wr_err", 64'(wr_err), 0);

    // full-throughput runs: first word two edges after start, done right after last word
    instr_ready = 1;
    for (int i = 0; i < 4; i++) begin
      logic [AW-1:0] last_a = 0;
      launch(v[i].sa, v[i].ea);
      chk($sformatf("v%0d_busy_t1", i), 64'(busy), 1);
      for (int t = 2; t <= v[i].n + 3; t++) begin
        bit ev;
        @(negedge clk);
        ev = t >= 3 && t < 3 + v[i].n;
        chk($sformatf("v%0d_valid_t%0d", i, t), 64'(instr_valid), 64'(ev));
        chk($sformatf("v%0d_done_t%0d", i, t), 64'(done), 64'(t == 3 + v[i].n));
        chk($sformatf("v%0d_busy_t%0d", i, t), 64'(busy), 64'(t < 3 + v[i].n));
        if (ev) begin
          exp_a = v[i].sa + AW'(t - 3);
          chk($sformatf("v%0d_addr_t%0d", i, t), 64'(instr_addr), 64'(exp_a));
          chk($sformatf("v%0d_data_t%0d", i, t), 64'(instr_data), 64'(exp_a));
          last_a = instr_addr;
        end
      end
      chk($sformatf("v%0d_last", i), 64'(last_a), 64'(v[i].last));
    end

    // backpressure: ready 1,0,0,1 repeating
    instr_ready = 0;
    launch(0, 5);
    k = 0; held = 0; seen = 0; hold_a = 0; hold_d = 0;
    for (int c = 0; c < 80 && !seen; c++) begin
      @(negedge clk);
      if (held) begin
        chk("bp_hold_valid", 64'(instr_valid), 1);
        chk("bp_hold_addr", 64'(instr_addr), 64'(hold_a));
        chk("bp_hold_data", 64'(instr_data), 64'(hold_d));
      end
      instr_ready = (c % 4 == 0) || (c % 4 == 3);
      if (instr_valid && instr_ready) begin
        chk("bp_addr", 64'(instr_addr), 64'(k));
        chk("bp_data", 64'(instr_data), 64'(k));
        k++;
      end
      held = instr_valid && !instr_ready;
      hold_a = instr_addr;
      hold_d = instr_data;
      seen = done;
    end
    chk("bp_count", 64'(k), 6);
    chk("bp_done", 64'(seen), 1);

    // loop mode: 2,3,2,3,... then drop loop after the fifth word
    instr_ready = 1; loop = 1;
    launch(2, 3);
    n = 0; seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (instr_valid) begin
        chk("loop_addr", 64'(instr_addr), (n % 2) ? 64'd3 : 64'd2);
        n++;
        if (n == 5) loop = 0;
      end
    end
    chk("loop_count", 64'(n), 6);
    chk("loop_done", 64'(seen), 1);
    loop = 0;

    // start and abort together while idle: abort wins
    @(negedge clk);
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("start_abort_busy", 64'(busy), 0);

    // idle write then readback
    @(negedge clk);
    wr_en = 1; wr_addr = 5; wr_data = PAT;
    @(negedge clk);
    wr_en = 0;
    chk("idle_wr_err", 64'(wr_err), 0);
    single("wr_read", 5, PAT);

    // write while fetching is dropped and flagged
    launch(0, 5);
    wr_en = 1; wr_addr = 5; wr_data = PAT2;
    @(negedge clk);
    wr_en = 0;
    chk("busy_wr_err", 64'(wr_err), 1);
    @(negedge clk);
    chk("busy_wr_err_pulse", 64'(wr_err), 0);
    wait_done("busy_wr_done");
    single("wr_keep", 5, PAT);

    // abort with buffer full under backpressure
    instr_ready = 0;
    launch(0, 5);
    repeat (4) @(negedge clk);
    chk("abort_pre_valid", 64'(instr_valid), 1);
    chk("abort_pre_addr", 64'(instr_addr), 0);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_valid", 64'(instr_valid), 0);
    chk("abort_busy", 64'(busy), 0);
    early = done;
    repeat (3) begin
      @(negedge clk);
      early = early | done | instr_valid;
    end
    chk("abort_quiet", 64'(early), 0);

    // asynchronous reset mid-run
    instr_ready = 1;
    launch(0, 5);
    repeat (2) @(negedge clk);
    chk("arst_pre_valid", 64'(instr_valid), 1);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 64'(instr_valid), 0);
    chk("arst_busy", 64'(busy), 0);
    chk("arst_done", 64'(done), 0);
    chk("arst_data", 64'(instr_data), 0);
    chk("arst_addr", 64'(instr_addr), 0);
    @(negedge clk);
    rst_n = 1;
    single("arst_mem", 5, PAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
